// File: rtl/onchip_memory_dualport.sv
// Dual-port on-chip RAM, two Avalon-MM slaves on one clock.
// Pipelined reads, s1-wins write collisions, sticky out-of-range flag.
module onchip_memory_dualport #(
  parameter int    DATA_W       = 32,
  parameter int    ADDR_W       = 17,
  parameter int    DEPTH        = 100000,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = "onchip_memory_dualport.hex"
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clken,
  input  logic                reset_req,
  input  logic [ADDR_W-1:0]   s1_address,
  input  logic                s1_chipselect,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  input  logic [DATA_W-1:0]   s1_writedata,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,
  output logic                s1_waitrequest,
  input  logic [ADDR_W-1:0]   s2_address,
  input  logic                s2_chipselect,
  input  logic                s2_read,
  input  logic                s2_write,
  input  logic [DATA_W/8-1:0] s2_byteenable,
  input  logic [DATA_W-1:0]   s2_writedata,
  output logic [DATA_W-1:0]   s2_readdata,
  output logic                s2_readdatavalid,
  output logic                s2_waitrequest,
  output logic                oob_error
);

  localparam int BE_W = DATA_W / 8;
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  // Initial contents come from the device image at configuration.
  (* ram_init_file = INIT_FILE *)
  logic [DATA_W-1:0] mem [DEPTH];

  logic              run;
  logic              collision;
  logic [ADDR_W-1:0] addr  [2];
  logic [IW-1:0]     idx   [2];
  logic [BE_W-1:0]   be    [2];
  logic [DATA_W-1:0] wd    [2];
  logic [DATA_W-1:0] rdat  [2];
  logic [1:0]        cs;
  logic [1:0]        rd;
  logic [1:0]        wr;
  logic [1:0]        acc;
  logic [1:0]        inr;
  logic [1:0]        wr_ok;
  logic [1:0]        rd_ok;

  logic [1:0]        v0;
  logic [DATA_W-1:0] d0    [2];
  logic [1:0]        vout;
  logic [DATA_W-1:0] dout  [2];

  assign run = clken & ~reset_req & ~reset;

  assign addr[0] = s1_address;
  assign addr[1] = s2_address;
  assign be[0]   = s1_byteenable;
  assign be[1]   = s2_byteenable;
  assign wd[0]   = s1_writedata;
  assign wd[1]   = s2_writedata;
  assign cs      = {s2_chipselect, s1_chipselect};
  assign rd      = {s2_read, s1_read};
  assign wr      = {s2_write, s1_write};

  // Same-address double write: s1 goes first, s2 retries next cycle.
  assign collision = cs[0] & wr[0] & cs[1] & wr[1]
                   & (addr[0] == addr[1]);

  assign s1_waitrequest = ~run;
  assign s2_waitrequest = ~run | collision;

  // Accept decode; read+write together counts as a write only.
  always_comb begin
    acc   = '0;
    inr   = '0;
    wr_ok = '0;
    rd_ok = '0;
    acc[0] = cs[0] & (rd[0] | wr[0]) & run;
    acc[1] = cs[1] & (rd[1] | wr[1]) & run & ~collision;
    for (int p = 0; p < 2; p++) begin
      inr[p]   = {1'b0, addr[p]} < DEPTH_C;
      wr_ok[p] = acc[p] & wr[p] & inr[p];
      rd_ok[p] = acc[p] & ~wr[p];
    end
  end

  // RAM read port; out-of-range reads return zero.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      idx[p]  = addr[p][IW-1:0];
      rdat[p] = '0;
      if (inr[p]) rdat[p] = mem[idx[p]];
    end
  end

  // Byte-lane writes; collisions never reach here for both ports.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wr_ok[p] && be[p][b])
          mem[idx[p]][8*b +: 8] <= wd[p][8*b +: 8];
      end
    end
  end

  // First read stage: captures old RAM data at the accepting edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      v0 <= '0;
      for (int p = 0; p < 2; p++) d0[p] <= '0;
    end else if (run) begin
      v0 <= rd_ok;
      for (int p = 0; p < 2; p++)
        if (rd_ok[p]) d0[p] <= rdat[p];
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [1:0]        v1;
    logic [DATA_W-1:0] d1 [2];

    // Extra output register stage.
    always_ff @(posedge clk) begin
      if (reset) begin
        v1 <= '0;
        for (int p = 0; p < 2; p++) d1[p] <= '0;
      end else if (run) begin
        v1 <= v0;
        for (int p = 0; p < 2; p++)
          if (v0[p]) d1[p] <= d0[p];
      end
    end

    assign vout    = v1;
    assign dout[0] = d1[0];
    assign dout[1] = d1[1];
  end else begin : g_lat1
    assign vout    = v0;
    assign dout[0] = d0[0];
    assign dout[1] = d0[1];
  end

  // Sticky flag for any accepted access beyond DEPTH.
  always_ff @(posedge clk) begin
    if (reset)
      oob_error <= 1'b0;
    else if (|(acc & ~inr))
      oob_error <= 1'b1;
  end

  assign s1_readdata      = dout[0];
  assign s2_readdata      = dout[1];
  assign s1_readdatavalid = vout[0] & run;
  assign s2_readdatavalid = vout[1] & run;

endmodule

// File: tb/tb_onchip_memory_dualport.sv
// Bench for onchip_memory_dualport: LAT=1 and LAT=2 copies on shared
// stimulus, directed table, corner sequences, random vs. queue model.
module tb_onchip_memory_dualport;

  localparam int DEPTH = 100000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, clken, reset_req;
  logic [16:0] a1, a2;
  logic        cs1, rd1, wr1, cs2, rd2, wr2;
  logic [3:0]  be1, be2;
  logic [31:0] wd1, wd2;

  // index: 0=u1.s1 1=u1.s2 2=u2.s1 3=u2.s2
  logic [3:0][31:0] rdata;
  logic [3:0]       rvalid;
  logic [3:0]       wq;
  logic [1:0]       oob;

  onchip_memory_dualport #(.READ_LATENCY(1), .INIT_FILE("")) u1 (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .s1_address(a1), .s1_chipselect(cs1), .s1_read(rd1),
    .s1_write(wr1), .s1_byteenable(be1), .s1_writedata(wd1),
    .s1_readdata(rdata[0]), .s1_readdatavalid(rvalid[0]),
    .s1_waitrequest(wq[0]),
    .s2_address(a2), .s2_chipselect(cs2), .s2_read(rd2),
    .s2_write(wr2), .s2_byteenable(be2), .s2_writedata(wd2),
    .s2_readdata(rdata[1]), .s2_readdatavalid(rvalid[1]),
    .s2_waitrequest(wq[1]),
    .oob_error(oob[0])
  );

  onchip_memory_dualport #(.READ_LATENCY(2), .INIT_FILE("")) u2 (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .s1_address(a1), .s1_chipselect(cs1), .s1_read(rd1),
    .s1_write(wr1), .s1_byteenable(be1), .s1_writedata(wd1),
    .s1_readdata(rdata[2]), .s1_readdatavalid(rvalid[2]),
    .s1_waitrequest(wq[2]),
    .s2_address(a2), .s2_chipselect(cs2), .s2_read(rd2),
    .s2_write(wr2), .s2_byteenable(be2), .s2_writedata(wd2),
    .s2_readdata(rdata[3]), .s2_readdatavalid(rvalid[3]),
    .s2_waitrequest(wq[3]),
    .oob_error(oob[1])
  );

  int total = 0;
  int bad   = 0;

  // Reference: memory as a sparse map, per-port queue of pending reads.
  typedef struct {
    logic [31:0] d;
    bit          known;
    int          age;
  } ent_t;

  logic [31:0] mm [int];
  ent_t        q [4][$];
  logic [31:0] last [4];
  bit          lknown [4];
  bit          exp_oob = 1'b0;

  function automatic int lat(input int i);
    return (i < 2) ? 1 : 2;
  endfunction

  function automatic bit vis(input int i);
    if (q[i].size() == 0) return 1'b0;
    return q[i][0].age == lat(i) - 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    cs1 = 0; rd1 = 0; wr1 = 0;
    cs2 = 0; rd2 = 0; wr2 = 0;
  endtask

  task automatic drv(input int p, input bit c, input bit r,
                     input bit w, input logic [16:0] a,
                     input logic [3:0] b, input logic [31:0] d);
    if (p == 1) begin
      cs1 = c; rd1 = r; wr1 = w; a1 = a; be1 = b; wd1 = d;
    end else begin
      cs2 = c; rd2 = r; wr2 = w; a2 = a; be2 = b; wd2 = d;
    end
  endtask

  task automatic model_edge(input bit run, input bit coll);
    bit          acc [2];
    bit          r [2];
    bit          w [2];
    int          ad [2];
    logic [3:0]  bb [2];
    logic [31:0] dd [2];
    ent_t        e;
    logic [31:0] t;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        q[i].delete();
        last[i] = '0;
        lknown[i] = 1'b1;
      end
      exp_oob = 1'b0;
      return;
    end
    if (!run) return;
    r[0] = rd1; w[0] = wr1; ad[0] = int'(a1); bb[0] = be1; dd[0] = wd1;
    r[1] = rd2; w[1] = wr2; ad[1] = int'(a2); bb[1] = be2; dd[1] = wd2;
    acc[0] = cs1 && (rd1 || wr1);
    acc[1] = cs2 && (rd2 || wr2) && !coll;
    for (int i = 0; i < 4; i++) begin
      if (vis(i)) void'(q[i].pop_front());
      for (int j = 0; j < q[i].size(); j++) begin
        e = q[i][j];
        e.age++;
        q[i][j] = e;
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (acc[p] && r[p] && !w[p]) begin
        e.age = 0;
        if (ad[p] >= DEPTH) begin
          e.d = '0; e.known = 1'b1;
        end else if (mm.exists(ad[p])) begin
          e.d = mm[ad[p]]; e.known = 1'b1;
        end else begin
          e.d = '0; e.known = 1'b0;
        end
        q[p].push_back(e);
        q[p+2].push_back(e);
      end
      if (acc[p] && ad[p] >= DEPTH) exp_oob = 1'b1;
    end
    for (int p = 0; p < 2; p++) begin
      if (acc[p] && w[p] && ad[p] < DEPTH) begin
        if (mm.exists(ad[p])) begin
          t = mm[ad[p]];
          for (int b = 0; b < 4; b++)
            if (bb[p][b]) t[8*b +: 8] = dd[p][8*b +: 8];
          mm[ad[p]] = t;
        end else if (bb[p] == 4'hF) begin
          mm[ad[p]] = dd[p];
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (vis(i)) begin
        last[i] = q[i][0].d;
        lknown[i] = q[i][0].known;
      end
    end
  endtask

  // One clock: check handshake, advance model, check outputs.
  task automatic step();
    bit run, coll, ev;
    #1;
    run  = clken && !reset_req && !reset;
    coll = cs1 && wr1 && cs2 && wr2 && (a1 == a2);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("wait s1 u%0d", d), 32'(wq[2*d]), 32'(!run));
      chk($sformatf("wait s2 u%0d", d), 32'(wq[2*d+1]),
          32'(!run || coll));
    end
    @(posedge clk);
    model_edge(run, coll);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      ev = run && vis(i);
      chk($sformatf("valid %0d", i), 32'(rvalid[i]), 32'(ev));
      if ((run || reset) && lknown[i])
        chk($sformatf("data %0d", i), rdata[i], last[i]);
    end
    if (!$isunknown(oob) || reset == 1'b0)
      for (int d = 0; d < 2; d++)
        chk($sformatf("oob u%0d", d), 32'(oob[d]), 32'(exp_oob));
  endtask

  typedef struct {
    int          port;
    logic [16:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int          k, c0, c1, cs1n, f0, f1;
    logic [31:0] got [$];

    tbl[0] = '{1, 17'h00010, 4'hF, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[1] = '{1, 17'h00011, 4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    tbl[2] = '{1, 17'h00011, 4'h5, 32'h11223344, 32'hFF22FF44};
    tbl[3] = '{2, 17'h00012, 4'hF, 32'hCAFEF00D, 32'hCAFEF00D};
    tbl[4] = '{2, 17'h00012, 4'h0, 32'h12345678, 32'hCAFEF00D};
    tbl[5] = '{2, 17'h00012, 4'hA, 32'h55667788, 32'h55FE770D};
    tbl[6] = '{1, 17'd99999,  4'hF, 32'h0BADC0DE, 32'h0BADC0DE};
    tbl[7] = '{2, 17'd100000, 4'hF, 32'h00000001, 32'h00000000};
    tbl[8] = '{1, 17'h1FFFF,  4'hF, 32'h12345678, 32'h00000000};

    for (int i = 0; i < 4; i++) begin
      last[i] = '0;
      lknown[i] = 1'b0;
    end
    reset = 1; clken = 1; reset_req = 0;
    a1 = '0; a2 = '0; be1 = '0; be2 = '0; wd1 = '0; wd2 = '0;
    idle();
    step();
    step();
    reset = 0;
    step();

    // Directed write/readback table, both latencies.
    for (int i = 0; i < 9; i++) begin
      k = tbl[i].port - 1;
      idle();
      drv(tbl[i].port, 1, 0, 1, tbl[i].addr, tbl[i].be, tbl[i].wd);
      step();
      idle();
      drv(tbl[i].port, 1, 1, 0, tbl[i].addr, 4'h0, 32'h0);
      step();
      chk($sformatf("tbl%0d v lat1", i), 32'(rvalid[k]), 32'd1);
      chk($sformatf("tbl%0d d lat1", i), rdata[k], tbl[i].exp);
      idle();
      step();
      chk($sformatf("tbl%0d v lat2", i), 32'(rvalid[2+k]), 32'd1);
      chk($sformatf("tbl%0d d lat2", i), rdata[2+k], tbl[i].exp);
    end

    // Same-address write collision: s2 stalls once, its data wins.
    idle();
    drv(1, 1, 0, 1, 17'h20, 4'hF, 32'hAAAA0000);
    drv(2, 1, 0, 1, 17'h20, 4'hF, 32'h0000BBBB);
    #1;
    chk("coll s2 wait u1", 32'(wq[1]), 32'd1);
    chk("coll s2 wait u2", 32'(wq[3]), 32'd1);
    chk("coll s1 go", 32'(wq[0]), 32'd0);
    step();
    drv(1, 0, 0, 0, 17'h20, 4'hF, 32'h0);
    #1;
    chk("coll s2 retry", 32'(wq[1]), 32'd0);
    step();
    idle();
    drv(1, 1, 1, 0, 17'h20, 4'h0, 32'h0);
    step();
    chk("coll readback", rdata[0], 32'h0000BBBB);
    idle();
    step();

    // LAT=2 back-to-back burst with cross-port write to 0x3.
    for (int i = 0; i < 8; i++) begin
      idle();
      drv(1, 1, 0, 1, 17'(i), 4'hF, 32'h100 + 32'(i));
      step();
    end
    f0 = -1; f1 = -1;
    for (int i = 0; i < 10; i++) begin
      idle();
      if (i < 8) drv(2, 1, 1, 0, 17'(i), 4'h0, 32'h0);
      if (i == 3) drv(1, 1, 0, 1, 17'h3, 4'hF, 32'hFFFF0003);
      step();
      if (rvalid[3]) begin
        got.push_back(rdata[3]);
        if (f1 < 0) f1 = i;
      end
      if (rvalid[1] && f0 < 0) f0 = i;
    end
    chk("burst count", 32'(got.size()), 32'd8);
    chk("burst first lat2", 32'(f1), 32'd1);
    chk("burst first lat1", 32'(f0), 32'd0);
    if (got.size() == 8) begin
      chk("burst old data", got[3], 32'h103);
      chk("burst last", got[7], 32'h107);
    end
    idle();
    drv(2, 1, 1, 0, 17'h3, 4'h0, 32'h0);
    step();
    chk("new data 3", rdata[1], 32'hFFFF0003);
    idle();
    step();

    // Stall with a read in flight.
    drv(1, 1, 1, 0, 17'h10, 4'h0, 32'h0);
    step();
    c0 = int'(rvalid[0]); c1 = int'(rvalid[2]);
    idle();
    clken = 0;
    cs1n = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      c0 += int'(rvalid[0]);
      cs1n += int'(rvalid[2]);
    end
    clken = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      c0 += int'(rvalid[0]);
      c1 += int'(rvalid[2]);
    end
    chk("stall lat2 hidden", 32'(cs1n), 32'd0);
    chk("stall lat1 pulses", 32'(c0), 32'd1);
    chk("stall lat2 pulses", 32'(c1), 32'd1);

    // Reset in the middle of a read burst.
    for (int i = 0; i < 3; i++) begin
      idle();
      drv(1, 1, 1, 0, 17'h10 + 17'(i), 4'h0, 32'h0);
      step();
    end
    idle();
    reset = 1;
    c0 = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) reset = 0;
      step();
      c0 += int'(rvalid[0]) + int'(rvalid[2]);
    end
    chk("reset no pulse", 32'(c0), 32'd0);
    chk("reset data u1", rdata[0], 32'h0);
    chk("reset data u2", rdata[2], 32'h0);

    // Out-of-range read and sticky flag.
    drv(1, 1, 1, 0, 17'd100000, 4'h0, 32'h0);
    step();
    chk("oob valid", 32'(rvalid[0]), 32'd1);
    chk("oob data", rdata[0], 32'h0);
    chk("oob flag", 32'(oob[0]), 32'd1);
    idle();
    for (int i = 0; i < 3; i++) step();
    chk("oob sticky", 32'(oob[1]), 32'd1);
    reset = 1;
    step();
    chk("oob cleared", 32'(oob[0]), 32'd0);
    reset = 0;
    step();

    // Random traffic on a small window plus out-of-range hits.
    for (int i = 0; i < 16; i++) begin
      idle();
      drv(1, 1, 0, 1, 17'(i), 4'hF, $urandom);
      step();
    end
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 299) == 0);
      clken     = ($urandom_range(0, 7) != 0);
      reset_req = ($urandom_range(0, 15) == 0);
      for (int p = 1; p <= 2; p++) begin
        int          op;
        logic [16:0] ra;
        op = $urandom_range(0, 3);
        if ($urandom_range(0, 15) == 0)
          ra = $urandom_range(0, 1) ? 17'(DEPTH + $urandom_range(0, 3))
                                    : 17'h1FFFF;
        else
          ra = 17'($urandom_range(0, 15));
        drv(p, $urandom_range(0, 3) != 0, op != 1,
            op == 1 || op == 2, ra, 4'($urandom), $urandom);
      end
      step();
    end

    reset = 0; clken = 1; reset_req = 0;
    idle();
    step();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
